// File: rtl/regfile_scoreboard_if.sv
// Bundles the register file's read, write, issue and status signals.
//   master modport: the pipeline side (decode/issue and writeback); it drives
//                   addresses, write data and issue marks, and receives read
//                   data, pending flags and the pending count.
//   slave modport:  the register file itself.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // Read ports
    logic [ADDR_WIDTH-1:0]   raddr1;
    logic [ADDR_WIDTH-1:0]   raddr2;
    logic [DATA_WIDTH-1:0]   rdata1;
    logic [DATA_WIDTH-1:0]   rdata2;
    logic                    rpend1;
    logic                    rpend2;
    // Writeback port
    logic                    we;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH/8-1:0] wbe;
    logic [DATA_WIDTH-1:0]   wdata;
    // Issue marks
    logic                    issue_valid;
    logic [ADDR_WIDTH-1:0]   issue_rd;
    // Status
    logic [ADDR_WIDTH:0]     pend_count;

    modport master (
        output raddr1, raddr2, we, waddr, wbe, wdata, issue_valid, issue_rd,
        input  rdata1, rdata2, rpend1, rpend2, pend_count
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wbe, wdata, issue_valid, issue_rd,
        output rdata1, rdata2, rpend1, rpend2, pend_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with a pending-write scoreboard for the pipelined processor.
// Two combinational read ports, one byte-enabled write port with optional
// write-to-read bypass, and one pending bit per register that is set by the
// issue stage and cleared by writeback, so issue can detect RAW hazards
// against in-flight multi-cycle results.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (clears data, pending bits, count)
//   bus   - slave side of regfile_scoreboard_if (read ports, write port,
//           issue marks, registered pend_count)
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]      pending_reg;
    logic [DEPTH-1:0]      pending_next;
    logic [ADDR_WIDTH:0]   pend_count_reg;
    logic [ADDR_WIDTH:0]   pend_count_next;

    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  wr_ok;
    logic                  set_ok;

    // True when the address names the hardwired zero register.
    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Merged write word: the value the target register holds after the edge.
    // Shared by the write path and the bypass path so both always agree.
    assign wr_old = regs_reg[bus.waddr];

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign wr_merged[gi*8 +: 8] = bus.wbe[gi] ? bus.wdata[gi*8 +: 8]
                                                      : wr_old[gi*8 +: 8];
        end
    endgenerate

    assign wr_ok  = bus.we && !is_zero(bus.waddr);
    assign set_ok = bus.issue_valid && !is_zero(bus.issue_rd);

    // Read ports, built identically from one template.
    logic [ADDR_WIDTH-1:0] raddr_port [2];
    logic [DATA_WIDTH-1:0] rdata_port [2];
    logic                  rpend_port [2];

    assign raddr_port[0] = bus.raddr1;
    assign raddr_port[1] = bus.raddr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            logic hit;
            // A same-cycle write to the read address; the zero register is
            // excluded by the is_zero check below.
            assign hit = (BYPASS != 0) && bus.we && (bus.waddr == raddr_port[gi]);

            always_comb begin
                rdata_port[gi] = regs_reg[raddr_port[gi]];
                rpend_port[gi] = pending_reg[raddr_port[gi]];
                if (is_zero(raddr_port[gi])) begin
                    rdata_port[gi] = '0;
                    rpend_port[gi] = 1'b0;
                end else if (hit) begin
                    // The write resolves this register's outstanding result,
                    // so the reader sees the new value and no hazard.
                    rdata_port[gi] = wr_merged;
                    rpend_port[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign bus.rdata1     = rdata_port[0];
    assign bus.rdata2     = rdata_port[1];
    assign bus.rpend1     = rpend_port[0];
    assign bus.rpend2     = rpend_port[1];
    assign bus.pend_count = pend_count_reg;

    // Scoreboard update: clear on writeback first, then set on issue, so a
    // simultaneous issue to the same register leaves the bit set (the newer
    // producer is still outstanding).
    always_comb begin
        pending_next    = pending_reg;
        pend_count_next = '0;
        if (bus.we) begin
            pending_next[bus.waddr] = 1'b0;
        end
        if (set_ok) begin
            pending_next[bus.issue_rd] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            pend_count_next = pend_count_next + {{ADDR_WIDTH{1'b0}}, pending_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            pending_reg    <= '0;
            pend_count_reg <= '0;
        end else begin
            if (wr_ok) begin
                regs_reg[bus.waddr] <= wr_merged;
            end
            pending_reg    <= pending_next;
            pend_count_reg <= pend_count_next;
        end
    end
endmodule
